uart_tx_fifo_drain: RTL



---
 rtl/uart_tx_fifo_drain_pkg.sv | 19 +
 rtl/uart_tx_fifo_drain_if.sv | 21 ++
 rtl/uart_tx_fifo_drain_baud_tick_gen.sv | 27 ++
 rtl/uart_tx_fifo_drain.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/uart_tx_fifo_drain_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes and oversample rate.
// The UART receiver imports the same package.
package uart_tx_fifo_drain_pkg;

    localparam int OVERSAMPLE = 16;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo_drain_if.sv
// Show-ahead FIFO read port. The master drains the FIFO by pulsing fifo_rd;
// the slave is the FIFO itself.
interface uart_tx_fifo_drain_if #(
    parameter int DATA_BITS = 8
);
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_data;
    logic                 fifo_rd;

    modport master (
        input  fifo_empty,
        input  fifo_data,
        output fifo_rd
    );

    modport slave (
        output fifo_empty,
        output fifo_data,
        input  fifo_rd
    );
endinterface

// File: rtl/uart_tx_fifo_drain_baud_tick_gen.sv
// Oversample tick generator: one s_tick every BAUD_DIV enabled clk cycles.
// Shared by the UART transmitter and receiver.
module baud_tick_gen #(
    parameter int BAUD_DIV = 651
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic s_tick
);
    localparam int DIV_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BAUD_DIV - 1);

    logic [DIV_W-1:0] div_reg;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            div_reg <= '0;
        end else if (enable) begin
            div_reg <= (div_reg == DIV_LAST) ? '0 : div_reg + 1'b1;
        end
    end

    assign s_tick = enable && (div_reg == DIV_LAST);

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter draining a show-ahead TX FIFO: pops one word when idle,
// then sends start, LSB-first data, optional parity and stop on tx.
module uart_tx_fifo_drain
    import uart_tx_fifo_drain_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int BAUD_DIV   = 651,
    parameter int STOP_TICKS = 16,
    parameter int PARITY     = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tx_enable,
    uart_tx_fifo_drain_if.master  fifo,
    output logic                  tx,
    output logic                  tx_busy,
    output logic                  tx_done_tick
);
    localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [4:0]       BIT_TICK_LAST  = 5'(OVERSAMPLE - 1);
    localparam logic [4:0]       STOP_TICK_LAST = 5'(STOP_TICKS - 1);
    localparam logic [BIT_W-1:0] DATA_BIT_LAST  = BIT_W'(DATA_BITS - 1);

    tx_state_t            state_reg;
    logic [4:0]           tick_reg;
    logic [BIT_W-1:0]     bit_reg;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 parity_reg;
    logic                 tx_reg;
    logic                 done_reg;
    logic                 s_tick;
    logic                 pop;
    logic                 parity_next;

    assign pop         = (state_reg == ST_IDLE) && !fifo.fifo_empty && tx_enable;
    assign parity_next = (^fifo.fifo_data) ^ (PARITY == PAR_ODD);

    // Divider is cleared on the pop edge so every frame's timing starts fresh.
    baud_tick_gen #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud (
        .clk    (clk),
        .reset  (reset),
        .clear  (pop),
        .enable (tx_busy),
        .s_tick (s_tick)
    );

    always_ff @(posedge clk) begin
        done_reg <= 1'b0;
        if (reset) begin
            state_reg  <= ST_IDLE;
            tick_reg   <= '0;
            bit_reg    <= '0;
            shift_reg  <= '0;
            parity_reg <= 1'b0;
            tx_reg     <= 1'b1;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    tx_reg <= 1'b1;
                    if (pop) begin
                        shift_reg  <= fifo.fifo_data;
                        parity_reg <= parity_next;
                        tick_reg   <= '0;
                        tx_reg     <= 1'b0;
                        state_reg  <= ST_START;
                    end
                end
                ST_START: begin
                    if (s_tick) begin
                        if (tick_reg == BIT_TICK_LAST) begin
                            tick_reg  <= '0;
                            bit_reg   <= '0;
                            tx_reg    <= shift_reg[0];
                            state_reg <= ST_DATA;
                        end else begin
                            tick_reg <= tick_reg + 5'd1;
                        end
                    end
                end
                ST_DATA: begin
                    if (s_tick) begin
                        if (tick_reg == BIT_TICK_LAST) begin
                            tick_reg  <= '0;
                            shift_reg <= shift_reg >> 1;
                            if (bit_reg == DATA_BIT_LAST) begin
                                if (PARITY != PAR_NONE) begin
                                    tx_reg    <= parity_reg;
                                    state_reg <= ST_PARITY;
                                end else begin
                                    tx_reg    <= 1'b1;
                                    state_reg <= ST_STOP;
                                end
                            end else begin
                                bit_reg <= bit_reg + 1'b1;
                                // shift_reg[1] becomes bit 0 after this shift.
                                tx_reg  <= shift_reg[1];
                            end
                        end else begin
                            tick_reg <= tick_reg + 5'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (s_tick) begin
                        if (tick_reg == BIT_TICK_LAST) begin
                            tick_reg  <= '0;
                            tx_reg    <= 1'b1;
                            state_reg <= ST_STOP;
                        end else begin
                            tick_reg <= tick_reg + 5'd1;
                        end
                    end
                end
                ST_STOP: begin
                    if (s_tick) begin
                        if (tick_reg == STOP_TICK_LAST) begin
                            tick_reg  <= '0;
                            done_reg  <= 1'b1;
                            state_reg <= ST_IDLE;
                        end else begin
                            tick_reg <= tick_reg + 5'd1;
                        end
                    end
                end
                default: begin
                    tx_reg    <= 1'b1;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign fifo.fifo_rd = pop;
    assign tx           = tx_reg;
    assign tx_busy      = (state_reg != ST_IDLE);
    assign tx_done_tick = done_reg;

endmodule
